vec3_pair_packer: RTL and testbench

// - Producer-side feeder for the FIFO vector math units (add/sub/dot/cross).
// - Pops signed scalar words from an upstream first-word-fall-through (FWFT) FIFO.
// - Assembles each group of six words into an operand pair (x[2:0], y[2:0]).
// - Pushes each pair into the operand FIFO in one write. That FIFO's empty/rd_en/dout side feeds the math unit.

---
 rtl/vec3_pair_packer_pkg.sv | 30 +++
 rtl/vec3_pair_packer.sv | 74 +++++++
 tb/tb_vec3_pair_packer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/vec3_pair_packer_pkg.sv
// Shared types and constants for the vec3 pair packer and the vector math FIFOs it feeds.
package vec3_pair_packer_pkg;

  typedef logic signed [31:0] vec3_t [2:0];

  localparam int unsigned WORDS_PER_PAIR = 6;
  localparam int unsigned IDX_W          = 3;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(WORDS_PER_PAIR - 1);
  localparam idx_t Y_BASE   = idx_t'(3);

  typedef enum logic [0:0] {
    StCollect,
    StWrite
  } state_e;

  // Word k of a group lands in component k of x, or component k-3 of y.
  function automatic logic [1:0] slot_of(idx_t idx);
    idx_t rel;
    rel = (idx < Y_BASE) ? idx : idx - Y_BASE;
    return rel[1:0];
  endfunction

  function automatic logic is_x_word(idx_t idx);
    return idx < Y_BASE;
  endfunction

endpackage

// File: rtl/vec3_pair_packer.sv
// Pops six scalar words from an FWFT FIFO and pushes them as one (x, y) vec3 operand pair.
module vec3_pair_packer
  import vec3_pair_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_x [3],
  output logic [DATA_WIDTH-1:0] out_y [3],
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [CNT_WIDTH-1:0]  pair_count
);

  state_e state_q, state_d;
  idx_t   idx_q;
  logic   last_word;

  assign last_word = (idx_q == LAST_IDX);

  // Handshakes are gated by reset so a pending pair is never pushed and no word is
  // popped while the block is being cleared.
  always_comb begin
    state_d   = state_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (!in_empty && !reset) begin
          in_rd_en = 1'b1;
          if (last_word) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (!out_full && !reset) begin
          out_wr_en = 1'b1;
          state_d   = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StCollect;
      idx_q      <= '0;
      out_x      <= '{default: '0};
      out_y      <= '{default: '0};
      pair_count <= '0;
    end else begin
      state_q <= state_d;
      if (in_rd_en) begin
        if (is_x_word(idx_q)) begin
          out_x[slot_of(idx_q)] <= in_dout;
        end else begin
          out_y[slot_of(idx_q)] <= in_dout;
        end
        idx_q <= last_word ? '0 : idx_q + idx_t'(1);
      end
      if (out_wr_en) begin
        pair_count <= pair_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_vec3_pair_packer.sv
// Self-checking bench: queue-based upstream/downstream model with directed and random traffic.
module tb_vec3_pair_packer;

  logic        clock;
  logic        reset;
  logic [31:0] in_dout;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] out_x [3];
  logic [31:0] out_y [3];
  logic        out_full;
  logic        out_wr_en;
  logic [31:0] pair_count;

  vec3_pair_packer #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_dout    (in_dout),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .pair_count (pair_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Upstream FIFO contents and the words each pushed pair must contain, six per pair.
  logic [31:0] src [$];
  logic [31:0] exp_words [$];

  int  cyc = 0;
  int  start_cyc, first_wr_cyc, popped, writes;
  int  empty_pct, full_pct;
  bit  force_full;
  int  stall_after, stall_left, full_after, full_left;

  logic [31:0] prev_x [3];
  logic [31:0] prev_y [3];
  bit          prev_valid, prev_rd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock: drive inputs, observe at the falling edge, advance past the rising edge.
  task automatic cycle();
    bit stall_now, bp_now, fe;
    stall_now = (stall_left > 0) && (popped == stall_after);
    bp_now    = (full_left > 0) && (popped == full_after);
    fe = (src.size() == 0) || stall_now || ($urandom_range(99) < empty_pct);
    in_empty = fe;
    in_dout  = fe ? $urandom : src[0];
    out_full = force_full || bp_now || ($urandom_range(99) < full_pct);
    if (stall_now) stall_left--;
    if (bp_now) full_left--;

    @(negedge clock);
    check_eq("rd_wr_excl", {63'd0, in_rd_en & out_wr_en}, 64'd0);
    if (in_empty) check_eq("rd_when_empty", {63'd0, in_rd_en}, 64'd0);
    if (out_full) check_eq("wr_when_full", {63'd0, out_wr_en}, 64'd0);
    if (bp_now) check_eq("rd_during_backpressure", {63'd0, in_rd_en}, 64'd0);

    if (prev_valid && !prev_rd) begin
      for (int k = 0; k < 3; k++) begin
        check_eq($sformatf("stable_x%0d", k), {32'd0, out_x[k]}, {32'd0, prev_x[k]});
        check_eq($sformatf("stable_y%0d", k), {32'd0, out_y[k]}, {32'd0, prev_y[k]});
      end
    end
    prev_x = out_x;
    prev_y = out_y;
    prev_rd = in_rd_en;
    prev_valid = 1'b1;

    if (in_rd_en && src.size() > 0) begin
      void'(src.pop_front());
      popped++;
    end
    if (out_wr_en) begin
      if (exp_words.size() >= 6) begin
        for (int k = 0; k < 3; k++) begin
          check_eq($sformatf("pair%0d_x%0d", writes, k), {32'd0, out_x[k]}, {32'd0, exp_words[k]});
          check_eq($sformatf("pair%0d_y%0d", writes, k), {32'd0, out_y[k]},
                   {32'd0, exp_words[3+k]});
        end
        repeat (6) void'(exp_words.pop_front());
      end else begin
        check_eq("spurious_write", 64'd1, 64'd0);
      end
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      writes++;
    end

    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    start_cyc = cyc;
    first_wr_cyc = -1;
    popped = 0;
    writes = 0;
    while ((src.size() > 0 || exp_words.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    if (src.size() > 0 || exp_words.size() > 0) check_eq("timeout", 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_empty = 1'b1;
    in_dout = $urandom;
    out_full = 1'b0;
    @(negedge clock);
    check_eq("rst_rd_en", {63'd0, in_rd_en}, 64'd0);
    check_eq("rst_wr_en", {63'd0, out_wr_en}, 64'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check_eq("rst_count", {32'd0, pair_count}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_x", {32'd0, out_x[k]}, 64'd0);
      check_eq("rst_y", {32'd0, out_y[k]}, 64'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    prev_valid = 1'b0;
    cyc++;
  endtask

  task automatic push_pair(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5,
                           input bit expected);
    logic [31:0] w [6];
    w = '{w0, w1, w2, w3, w4, w5};
    for (int i = 0; i < 6; i++) begin
      src.push_back(w[i]);
      if (expected) exp_words.push_back(w[i]);
    end
  endtask

  initial begin
    empty_pct = 0;
    full_pct = 0;
    force_full = 1'b0;
    stall_after = -1; stall_left = 0;
    full_after = -1; full_left = 0;
    popped = 0;
    prev_valid = 1'b0;
    do_reset();

    // Basic pair and no-stall latency
    push_pair(1, 2, 3, 10, 20, 30, 1'b1);
    run(50);
    check_eq("basic_latency", 64'(first_wr_cyc - start_cyc), 64'd6);
    check_eq("basic_count", {32'd0, pair_count}, 64'd1);

    // Sign bits and extremes pass through untouched
    push_pair(32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFB, 32'd7, 1'b1);
    run(50);
    check_eq("neg_count", {32'd0, pair_count}, 64'd2);

    // Four empty cycles after word 2 delay the write by exactly four
    stall_after = 3; stall_left = 4;
    push_pair(11, 12, 13, 14, 15, 16, 1'b1);
    run(50);
    check_eq("stall_latency", 64'(first_wr_cyc - start_cyc), 64'd10);
    check_eq("stall_count", {32'd0, pair_count}, 64'd3);
    stall_after = -1;

    // Ten cycles of backpressure with the next group already waiting upstream
    full_after = 6; full_left = 10;
    push_pair(21, 22, 23, 24, 25, 26, 1'b1);
    push_pair(31, 32, 33, 34, 35, 36, 1'b1);
    run(100);
    check_eq("bp_latency", 64'(first_wr_cyc - start_cyc), 64'd16);
    check_eq("bp_count", {32'd0, pair_count}, 64'd5);
    full_after = -1;

    // Reset after four words drops the partial group
    src.push_back(41); src.push_back(42); src.push_back(43); src.push_back(44);
    run(50);
    do_reset();
    push_pair(7, 8, 9, 4, 5, 6, 1'b1);
    run(50);
    check_eq("midrst_count", {32'd0, pair_count}, 64'd1);

    // Reset while a completed pair waits on a full FIFO drops it
    do_reset();
    force_full = 1'b1;
    push_pair(51, 52, 53, 54, 55, 56, 1'b0);
    run(50);
    repeat (3) cycle();
    force_full = 1'b0;
    do_reset();
    repeat (5) cycle();
    check_eq("wrrst_count", {32'd0, pair_count}, 64'd0);

    // Random streaming traffic
    empty_pct = 30;
    full_pct = 30;
    for (int p = 0; p < 100; p++) begin
      push_pair($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
    end
    run(5000);
    check_eq("stream_count", {32'd0, pair_count}, 64'd100);
    check_eq("stream_writes", 64'(writes), 64'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
